sig_sync_filter: RTL and testbench

Parametrised input-conditioning register bank for the DPLL front end. It replaces the single D flip-flop stage with the following per channel:
- a multi-stage synchroniser;
- a consecutive-sample glitch filter;
- registered true/complement outputs;
- single-cycle rise/fall/glitch pulses.

Reference-clock and feedback-divider signals pass through it before reaching the phase detector.

---
 rtl/dpll_pkg.sv | 23 ++
 rtl/sig_filter_chan.sv | 107 ++++++++++
 rtl/sig_sync_filter.sv | 57 +++++
 tb/tb_sig_sync_filter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// -----------------------------------------------------------------------------
// dpll_pkg
// Shared definitions for the DPLL front end.
//   clog2()          : ceiling log2, usable in constant expressions
//   SYNC_STAGES_DEF  : default synchroniser depth
//   FILT_LEN_DEF     : default glitch-filter length (consecutive samples)
// -----------------------------------------------------------------------------
package dpll_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF    = 4;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sig_filter_chan.sv
// -----------------------------------------------------------------------------
// sig_filter_chan
// One input-conditioning channel: multi-stage synchroniser, consecutive-sample
// glitch filter, registered filtered output and single-cycle edge/glitch
// pulses.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-low reset
//   en      in   sample enable; when low all state holds and pulses are 0
//   sig_in  in   asynchronous raw input
//   sig_out out  filtered, registered signal
//   rise    out  1-cycle pulse when sig_out goes 0->1
//   fall    out  1-cycle pulse when sig_out goes 1->0
//   glitch  out  1-cycle pulse when a pending change is abandoned
// -----------------------------------------------------------------------------
module sig_filter_chan
    import dpll_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   FILT_LEN    = FILT_LEN_DEF,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sig_in,
    output logic sig_out,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int                CNT_W   = clog2(FILT_LEN) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_d,   sync_q;
    logic [CNT_W-1:0]       cnt_d,    cnt_q;
    logic                   out_d,    out_q;
    logic                   rise_d,   rise_q;
    logic                   fall_d,   fall_q;
    logic                   glitch_d, glitch_q;
    logic                   s_sync;

    // Oldest synchroniser stage is the only one the filter may look at.
    assign s_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; that is what keeps this block free of inferred latches.
        sync_d   = sync_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;

        if (en) begin
            sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};

            if (s_sync == out_q) begin
                // Input fell back before the change was accepted.
                if (cnt_q != '0) begin
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end
            end else if (cnt_q == CNT_MAX) begin
                // FILT_LEN-th consecutive differing sample: accept it.
                out_d  = s_sync;
                cnt_d  = '0;
                rise_d = s_sync;
                fall_d = ~s_sync;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // NOTE: the synchroniser chain is reset along with everything else so the
    // filter never compares against an unknown sample after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            cnt_q    <= '0;
            out_q    <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop load the value
            // computed from the pre-edge state, independent of statement order.
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign sig_out = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign glitch  = glitch_q;

endmodule

// File: rtl/sig_sync_filter.sv
// -----------------------------------------------------------------------------
// sig_sync_filter
// Input-conditioning register bank for the DPLL front end. Each of WIDTH
// independent channels synchronises, glitch-filters and edge-detects its raw
// input before it reaches the phase detector.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   en         in   sample enable; when low all state holds
//   sig_in     in   [WIDTH] asynchronous raw inputs
//   sig_out    out  [WIDTH] filtered, registered signals
//   sig_out_n  out  [WIDTH] complement of sig_out (from the same register)
//   rise       out  [WIDTH] 1-cycle pulse on sig_out 0->1
//   fall       out  [WIDTH] 1-cycle pulse on sig_out 1->0
//   glitch     out  [WIDTH] 1-cycle pulse when a pending change is abandoned
// -----------------------------------------------------------------------------
module sig_sync_filter
    import dpll_pkg::*;
#(
    parameter int   WIDTH       = 1,
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   FILT_LEN    = FILT_LEN_DEF,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] sig_out_n,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] glitch
);

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
        sig_filter_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .RESET_VAL   (RESET_VAL)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .sig_in  (sig_in[ch]),
            .sig_out (sig_out[ch]),
            .rise    (rise[ch]),
            .fall    (fall[ch]),
            .glitch  (glitch[ch])
        );
    end

    // Complement taken from the output register, so both rails are glitch-free.
    assign sig_out_n = ~sig_out;

endmodule

// File: tb/tb_sig_sync_filter.sv
// -----------------------------------------------------------------------------
// tb_sig_sync_filter
// Two instances share one clock, enable and reset:
//   dut_a : WIDTH=4, default SYNC_STAGES=2, FILT_LEN=4
//   dut_b : WIDTH=2, SYNC_STAGES=3, FILT_LEN=1
// Stimulus pushes the reference model's expected outputs into a queue after
// each clock edge; an independent monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_sig_sync_filter;

    typedef struct packed {
        logic [3:0] a_out;
        logic [3:0] a_rise;
        logic [3:0] a_fall;
        logic [3:0] a_glitch;
        logic [1:0] b_out;
        logic [1:0] b_rise;
        logic [1:0] b_fall;
        logic [1:0] b_glitch;
    } obs_t;

    localparam int NCH = 6; // channels 0..3 = dut_a, 4..5 = dut_b

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] a_in;
    logic [1:0] b_in;

    logic [3:0] a_out, a_out_n, a_rise, a_fall, a_glitch;
    logic [1:0] b_out, b_out_n, b_rise, b_fall, b_glitch;

    int tests_run = 0;
    int tests_failed = 0;

    obs_t sb[$];

    sig_sync_filter #(
        .WIDTH(4), .SYNC_STAGES(2), .FILT_LEN(4), .RESET_VAL(1'b0)
    ) dut_a (
        .clk(clk), .reset(rst), .en(en), .sig_in(a_in),
        .sig_out(a_out), .sig_out_n(a_out_n),
        .rise(a_rise), .fall(a_fall), .glitch(a_glitch)
    );

    sig_sync_filter #(
        .WIDTH(2), .SYNC_STAGES(3), .FILT_LEN(1), .RESET_VAL(1'b0)
    ) dut_b (
        .clk(clk), .reset(rst), .en(en), .sig_in(b_in),
        .sig_out(b_out), .sig_out_n(b_out_n),
        .rise(b_rise), .fall(b_fall), .glitch(b_glitch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each channel is a pure delay of SYNC_STAGES enabled samples (a queue)
    // followed by a run-length acceptance rule: the output takes the new value
    // once FILT_LEN consecutive delayed samples have disagreed with it.
    int stg  [NCH] = '{2, 2, 2, 2, 3, 3};
    int flen [NCH] = '{4, 4, 4, 4, 1, 1};
    bit pipe [NCH][$];
    bit out_m[NCH];
    int run_m[NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            pipe[c].delete();
            for (int k = 0; k < stg[c]; k++) pipe[c].push_back(1'b0);
            out_m[c] = 1'b0;
            run_m[c] = 0;
        end
    endtask

    task automatic model_step(input bit en_v, input logic [5:0] x, output obs_t e);
        bit s, r, f, g;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            r = 1'b0; f = 1'b0; g = 1'b0;
            if (en_v) begin
                pipe[c].push_back(x[c]);
                s = pipe[c].pop_front();
                if (s != out_m[c]) begin
                    run_m[c]++;
                    if (run_m[c] == flen[c]) begin
                        out_m[c] = s;
                        run_m[c] = 0;
                        r = s;
                        f = !s;
                    end
                end else begin
                    g = (run_m[c] != 0);
                    run_m[c] = 0;
                end
            end
            if (c < 4) begin
                e.a_out[c] = out_m[c]; e.a_rise[c] = r; e.a_fall[c] = f; e.a_glitch[c] = g;
            end else begin
                e.b_out[c-4] = out_m[c]; e.b_rise[c-4] = r; e.b_fall[c-4] = f; e.b_glitch[c-4] = g;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " a_out"},    {28'd0, a_out},    32'h0);
        check({tag, " a_out_n"},  {28'd0, a_out_n},  32'hF);
        check({tag, " a_pulses"}, {20'd0, a_rise, a_fall, a_glitch}, 32'h0);
        check({tag, " b_out"},    {30'd0, b_out},    32'h0);
        check({tag, " b_out_n"},  {30'd0, b_out_n},  32'h3);
        check({tag, " b_pulses"}, {26'd0, b_rise, b_fall, b_glitch}, 32'h0);
    endtask

    obs_t mon_exp, mon_act;
    always @(negedge clk) begin
        if (rst && sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_act = {a_out, a_rise, a_fall, a_glitch, b_out, b_rise, b_fall, b_glitch};
            check("cycle outputs", {8'd0, mon_act}, {8'd0, mon_exp});
            check("sig_out_n", {26'd0, a_out_n, b_out_n}, {26'd0, ~mon_exp.a_out, ~mon_exp.b_out});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input logic en_v, input logic [3:0] ai, input logic [1:0] bi);
        obs_t e;
        en   = en_v;
        a_in = ai;
        b_in = bi;
        @(posedge clk);
        model_step(en_v, {bi, ai}, e);
        sb.push_back(e);
        #1;
    endtask

    task automatic run(input int n, input logic en_v, input logic [3:0] ai, input logic [1:0] bi);
        for (int i = 0; i < n; i++) cycle(en_v, ai, bi);
    endtask

    // Asserts reset between edges and checks the outputs before the next edge.
    task automatic apply_reset(input int cycles);
        #2;
        rst = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check_reset_state("mid reset");
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        logic [3:0] ra;
        logic [1:0] rb;
        logic       re;

        rst  = 1'b0;
        en   = 1'b0;
        a_in = '0;
        b_in = '0;
        model_reset();
        #3;
        check_reset_state("power-on reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Clean steps: accepted after 6 edges (dut_a) / 4 edges (dut_b).
        run(8,  1'b1, 4'b0001, 2'b01);
        run(8,  1'b1, 4'b0000, 2'b00);

        // 3-sample pulse is rejected with one glitch; 4-sample pulse accepted.
        run(3,  1'b1, 4'b0001, 2'b00);
        run(8,  1'b1, 4'b0000, 2'b00);
        run(4,  1'b1, 4'b0001, 2'b00);
        run(12, 1'b1, 4'b0000, 2'b00);

        // Ch0 step at t, ch2 2-cycle glitch at t+1, ch1/ch3 quiet.
        cycle(1'b1, 4'b0001, 2'b00);
        run(2,  1'b1, 4'b0101, 2'b00);
        run(8,  1'b1, 4'b0001, 2'b00);
        run(10, 1'b1, 4'b0000, 2'b00);

        // Enable toggling stretches acceptance to 6 enabled edges.
        for (int i = 0; i < 16; i++) cycle(i[0] == 1'b0, 4'b0001, 2'b01);
        run(4,  1'b1, 4'b0001, 2'b01);
        for (int i = 0; i < 16; i++) cycle(i[0] == 1'b0, 4'b0000, 2'b00);
        run(4,  1'b1, 4'b0000, 2'b00);

        // dut_b: 1-cycle input pulse passes straight through.
        run(6,  1'b1, 4'b0000, 2'b01);
        cycle(1'b1, 4'b0000, 2'b11);
        run(6,  1'b1, 4'b0000, 2'b01);

        // Reset while ch0 (falling) and ch1 (rising) are at count 2.
        run(10, 1'b1, 4'b0001, 2'b00);
        run(4,  1'b1, 4'b0010, 2'b00);
        apply_reset(2);
        run(8,  1'b1, 4'b0010, 2'b00);

        // Randomised traffic: mostly enabled, inputs flip occasionally.
        ra = 4'b0010;
        rb = 2'b00;
        for (int i = 0; i < 600; i++) begin
            re = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 4) == 0) ra[c] = ~ra[c];
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 3) == 0) rb[c] = ~rb[c];
            cycle(re, ra, rb);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
